mem_access_ctrl: RTL

Multi-cycle memory subsystem that sits directly downstream of the pipelined MIPS core's memory interface. It services the core's instruction fetch port and its data load/store port from one shared single-port word array. It reports per-port access status on the 3-bit state buses that the core's freeze logic consumes. Fixed, parameterised access latency and data-over-instruction arbitration model a slow shared memory, so that the core's stall path is exercised.

---
 rtl/mem_access_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Shared single-port word memory serving the core's fetch port and data load/store port.
// Latency: IMEM_LAT/DMEM_LAT wait cycles plus one completion cycle; a lost arbitration adds a cycle.
// Backpressure: the per-port state buses show WAIT while an access is outstanding, and the core freezes on WAIT.
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   PC_for_Mem                  fetch byte address
//   MemRead/MemWrite_for_Mem    data load/store request (both high = store)
//   WD_for_Mem, ALU_Out_for_Mem store data, data byte address
//   ld_en/ld_addr/ld_data       backdoor preload write (highest priority)
//   INSTR_from_Mem, RDATA       registered fetch / load results
//   Instr_state, Mem_state      IDLE=000 WAIT=001 DONE=010 ERR=100
module mem_access_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int IMEM_LAT = 2,
  parameter int DMEM_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC_for_Mem,
  input  logic              MemRead_for_Mem,
  input  logic              MemWrite_for_Mem,
  input  logic [31:0]       WD_for_Mem,
  input  logic [31:0]       ALU_Out_for_Mem,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       INSTR_from_Mem,
  output logic [31:0]       RDATA,
  output logic [2:0]        Instr_state,
  output logic [2:0]        Mem_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_WAIT = 3'b001,
    S_DONE = 3'b010,
    S_ERR  = 3'b100
  } state_t;

  // Counters only ever hold LAT-1 down to 0.
  localparam int IC_W = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
  localparam int DC_W = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;
  localparam logic [IC_W-1:0] I_LOAD = IC_W'(IMEM_LAT - 1);
  localparam logic [DC_W-1:0] D_LOAD = DC_W'(DMEM_LAT - 1);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  state_t          istate, istate_nx, dstate, dstate_nx;
  logic [IC_W-1:0] icnt, icnt_nx;
  logic [DC_W-1:0] dcnt, dcnt_nx;

  // Completed-access tags: a port stays quiet while its inputs match the last completion.
  logic [31:0] ipc_q;
  logic        ivalid;
  logic [31:0] dadr_q, dwd_q;
  logic        dop_q, dvalid;

  logic [ADDR_W-1:0] iw, dw;
  logic i_mis, d_mis, i_pend, d_req, d_pend;
  logic i_try, d_try, i_gnt, d_gnt;

  // Upper address bits are dropped, so out-of-range addresses wrap.
  assign iw = PC_for_Mem[ADDR_W+1:2];
  assign dw = ALU_Out_for_Mem[ADDR_W+1:2];

  assign i_mis  = (PC_for_Mem[1:0] != 2'b00);
  assign d_mis  = (ALU_Out_for_Mem[1:0] != 2'b00);
  assign i_pend = !ivalid || (PC_for_Mem != ipc_q);
  assign d_req  = MemRead_for_Mem || MemWrite_for_Mem;
  assign d_pend = d_req && (!dvalid ||
                  ({ALU_Out_for_Mem, MemWrite_for_Mem, WD_for_Mem} != {dadr_q, dop_q, dwd_q}));

  // One array access per cycle: preload, then data, then fetch.
  assign i_try = (istate == S_WAIT) && (icnt == '0) && !i_mis;
  assign d_try = (dstate == S_WAIT) && (dcnt == '0) && d_req && !d_mis;
  assign d_gnt = d_try && !ld_en;
  assign i_gnt = i_try && !ld_en && !d_try;

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      istate <= S_IDLE;
      icnt   <= '0;
      dstate <= S_IDLE;
      dcnt   <= '0;
    end else begin
      istate <= istate_nx;
      icnt   <= icnt_nx;
      dstate <= dstate_nx;
      dcnt   <= dcnt_nx;
    end
  end

  // Fetch next state
  always_comb begin
    istate_nx = istate;
    icnt_nx   = icnt;
    unique case (istate)
      S_IDLE, S_DONE: begin
        if (!i_pend) begin
          istate_nx = S_IDLE;
        end else if (i_mis) begin
          istate_nx = S_ERR;
        end else begin
          istate_nx = S_WAIT;
          icnt_nx   = I_LOAD;
        end
      end
      S_WAIT: begin
        if (i_mis) begin
          istate_nx = S_ERR;
        end else if (i_gnt) begin
          istate_nx = S_DONE;
        end else if (icnt != '0) begin
          icnt_nx = icnt - IC_W'(1);
        end
      end
      S_ERR:   istate_nx = S_IDLE;
      default: istate_nx = S_IDLE;
    endcase
  end

  // Data next state; a request withdrawn mid-wait abandons the access.
  always_comb begin
    dstate_nx = dstate;
    dcnt_nx   = dcnt;
    unique case (dstate)
      S_IDLE, S_DONE: begin
        if (!d_pend) begin
          dstate_nx = S_IDLE;
        end else if (d_mis) begin
          dstate_nx = S_ERR;
        end else begin
          dstate_nx = S_WAIT;
          dcnt_nx   = D_LOAD;
        end
      end
      S_WAIT: begin
        if (!d_req) begin
          dstate_nx = S_IDLE;
        end else if (d_mis) begin
          dstate_nx = S_ERR;
        end else if (d_gnt) begin
          dstate_nx = S_DONE;
        end else if (dcnt != '0) begin
          dcnt_nx = dcnt - DC_W'(1);
        end
      end
      S_ERR:   dstate_nx = S_IDLE;
      default: dstate_nx = S_IDLE;
    endcase
  end

  // Status outputs: a fresh request shows WAIT in the cycle it appears so the core freezes at once.
  always_comb begin
    Instr_state = istate;
    Mem_state   = dstate;
    if (rst && (istate == S_IDLE) && i_pend) Instr_state = S_WAIT;
    if (rst && (dstate == S_IDLE) && d_pend) Mem_state   = S_WAIT;
  end

  // Result registers and completion tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      INSTR_from_Mem <= '0;
      RDATA          <= '0;
      ipc_q          <= '0;
      ivalid         <= 1'b0;
      dadr_q         <= '0;
      dwd_q          <= '0;
      dop_q          <= 1'b0;
      dvalid         <= 1'b0;
    end else begin
      if (i_gnt) begin
        INSTR_from_Mem <= mem[iw];
        ipc_q          <= PC_for_Mem;
        ivalid         <= 1'b1;
      end
      if (d_gnt) begin
        if (!MemWrite_for_Mem) RDATA <= mem[dw];
        dadr_q <= ALU_Out_for_Mem;
        dop_q  <= MemWrite_for_Mem;
        dwd_q  <= WD_for_Mem;
        dvalid <= 1'b1;
      end else if (!d_req) begin
        dvalid <= 1'b0;
      end
      if (dstate_nx == S_ERR) RDATA <= '0;
    end
  end

  // Array: not reset. A reset forces both ports idle, so no store can land during it.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (d_gnt && MemWrite_for_Mem) begin
      mem[dw] <= WD_for_Mem;
    end
  end

endmodule
